alu_share_ctrl: RTL

- Sequencer/arbiter that shares one 8-bit ALU datapath between NREQ requesters.
- Each requester issues {A, B, op} over a valid/ready handshake.
- The controller grants round-robin, drives the ALU from registered operands, captures result, zero and carry, and returns them over a per-requester valid/ready response channel.
- Sits between the requesting engines and the ALU instance.

---
 rtl/alu_share_ctrl_pkg.sv | 26 ++
 rtl/alu_share_ctrl_if.sv | 38 +++
 rtl/alu_share_ctrl_rr_arbiter.sv | 34 +++
 rtl/alu_share_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller: opcodes, default widths
// and the controller state encoding.
package alu_ctrl_pkg;

    localparam int DEF_DW  = 8;
    localparam int DEF_OPW = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_EQ  = 4'd8;
    localparam logic [3:0] OP_GT  = 4'd9;
    localparam logic [3:0] OP_LT  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response and ALU-side bus of the ALU-sharing controller.
// slave = controller view, master = requesters plus the ALU instance.
interface alu_share_ctrl_if #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int OPW  = 4
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [DW-1:0]       rsp_data;
    logic                rsp_zero;
    logic                rsp_carry;
    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic [OPW-1:0]      alu_sel;
    logic [DW-1:0]       alu_out;
    logic                alu_zero;
    logic                alu_carry;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
               alu_out, alu_zero, alu_carry,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry,
               alu_a, alu_b, alu_sel
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
               alu_out, alu_zero, alu_carry,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry,
               alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last'
// (wrapping), returning a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    // Two descending passes: the lowest index wins within a pass, and the
    // pass above 'last' overrides the wrapped pass at or below it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i <= int'(last))) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last))) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between NREQ requesters: round-robin grant, one-cycle execute,
// held response. Define ALU_SHARE_STATS_EN to add the op_count output.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = DEF_DW,
    parameter int OPW  = DEF_OPW
) (
    input  logic clk,
    input  logic rst_n,
    alu_share_ctrl_if.slave bus
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, nxt_state;
    logic [IW-1:0]   rr_last;
    logic [IW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] owner;
    logic            req_fire, rsp_fire, carry_op;

    logic [DW-1:0]   alu_a_q, alu_b_q, rsp_data_q;
    logic [OPW-1:0]  alu_sel_q;
    logic            rsp_zero_q, rsp_carry_q;
    logic [NREQ-1:0] req_ready_c, rsp_valid_c;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req     (bus.req_valid),
        .last    (rr_last),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // rr_last doubles as the owner of the in-flight op once granted.
    assign owner    = NREQ'(1) << rr_last;
    assign req_fire = (state == S_IDLE) && (|gnt);
    assign rsp_fire = (state == S_RESP) && (|(bus.rsp_ready & owner));
    assign carry_op = (alu_sel_q == OPW'(OP_ADD)) || (alu_sel_q == OPW'(OP_SUB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:  if (req_fire) nxt_state = S_EXEC;
            S_EXEC:  nxt_state = S_RESP;
            S_RESP:  if (rsp_fire) nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = '0;
        rsp_valid_c = '0;
        case (state)
            S_IDLE:  req_ready_c = gnt;
            S_RESP:  rsp_valid_c = owner;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last     <= IW'(NREQ - 1);
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
        end else begin
            if (req_fire) begin
                rr_last   <= gnt_idx;
                alu_a_q   <= bus.req_a[gnt_idx*DW +: DW];
                alu_b_q   <= bus.req_b[gnt_idx*DW +: DW];
                alu_sel_q <= bus.req_op[gnt_idx*OPW +: OPW];
            end
            if (state == S_EXEC) begin
                rsp_data_q  <= bus.alu_out;
                rsp_zero_q  <= bus.alu_zero;
                rsp_carry_q <= bus.alu_carry & carry_op;
            end
        end
    end

`ifdef ALU_SHARE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               op_count <= '0;
        else if (rsp_fire && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
`endif

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;

endmodule
